bcd_mod_counter: RTL

BCD_MOD_COUNTER -- requirements
Module: bcd_mod_counter

---
 rtl/bcd_pkg.sv | 50 +++++
 rtl/bcd_digit_step.sv | 37 +++
 rtl/bcd_mod_counter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// Shared constants and helpers for the BCD modulus counter.
// Holds the BCD digit width, the decimal digit maximum and the supported decade count.
package bcd_pkg;

    // Bits per BCD decade.
    localparam int unsigned BCD_W = 4;

    // Largest legal decimal digit.
    localparam int unsigned DIGIT_MAX = 9;

    // Largest number of decades a counter instance may have.
    localparam int unsigned MAX_DIGITS = 4;

    // DIGIT_MAX as a BCD nibble, for direct comparison against digits.
    localparam logic [BCD_W-1:0] DIGIT_MAX_BCD = 4'(DIGIT_MAX);

    // One extra decade so that a modulus of 10^MAX_DIGITS is still representable.
    localparam int unsigned BCD_FULL_W = BCD_W * (MAX_DIGITS + 1);

    // Action chosen on a clock edge, in priority order load > step > hold.
    typedef enum logic [1:0] {
        OpHold,
        OpLoad,
        OpStep
    } op_e;

    // 10^n, used to bound MODULUS at elaboration.
    function automatic int unsigned pow10(input int unsigned n);
        int unsigned r;
        r = 1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    // Binary-to-BCD conversion for elaboration-time constants.
    function automatic logic [BCD_FULL_W-1:0] to_bcd(input int unsigned value);
        logic [BCD_FULL_W-1:0] r;
        int unsigned v;
        r = '0;
        v = value;
        for (int unsigned i = 0; i < MAX_DIGITS + 1; i++) begin
            r[i*BCD_W +: BCD_W] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD decade of the counter's increment/decrement ripple chain.
// With carry_in set the digit steps by one in the chosen direction; carry_out
// flags the 9->0 (up) or 0->9 (down) rollover so the next decade steps too.
module bcd_digit_step
    import bcd_pkg::*;
(
    input  logic [BCD_W-1:0] digit,
    input  logic             up,
    input  logic             carry_in,
    output logic [BCD_W-1:0] next_digit,
    output logic             carry_out
);

    // Step the digit only when the lower decades ripple into it.
    always_comb begin
        next_digit = digit;
        carry_out  = 1'b0;
        if (carry_in) begin
            if (up) begin
                if (digit >= DIGIT_MAX_BCD) begin
                    next_digit = '0;
                    carry_out  = 1'b1;
                end else begin
                    next_digit = digit + 4'd1;
                end
            end else begin
                if (digit == '0) begin
                    next_digit = DIGIT_MAX_BCD;
                    carry_out  = 1'b1;
                end else begin
                    next_digit = digit - 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/bcd_mod_counter.sv
// Multi-decade BCD up/down counter with programmable modulus, synchronous load
// with validity checking, and registered wrap (carry/borrow) and load-error pulses.
// All outputs come straight from flops so instances can be chained carry -> en.
module bcd_mod_counter
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS  = 2,
    parameter int unsigned MODULUS = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic                    up,
    input  logic                    load,
    input  logic [BCD_W*DIGITS-1:0] load_val,
    output logic [BCD_W*DIGITS-1:0] count,
    output logic                    carry,
    output logic                    load_err
);

    localparam int unsigned W = BCD_W * DIGITS;

    // Reject illegal parameterisations at elaboration.
    if (DIGITS < 1 || DIGITS > MAX_DIGITS) begin : g_bad_digits
        $error("bcd_mod_counter: DIGITS must be in 1..%0d", MAX_DIGITS);
    end
    if (MODULUS < 2 || MODULUS > pow10(DIGITS)) begin : g_bad_modulus
        $error("bcd_mod_counter: MODULUS must be in 2..10^DIGITS");
    end

    // MODULUS carries one extra decade so 10^DIGITS does not overflow the compare.
    localparam logic [BCD_FULL_W-1:0] MOD_BCD_FULL = to_bcd(MODULUS);
    localparam logic [BCD_FULL_W-1:0] TOP_BCD_FULL = to_bcd(MODULUS - 1);
    localparam logic [W+BCD_W-1:0]    MOD_BCD      = MOD_BCD_FULL[W+BCD_W-1:0];
    localparam logic [W-1:0]          TOP_VAL      = TOP_BCD_FULL[W-1:0];

    logic [W-1:0]  count_q, count_d;
    logic          carry_q, carry_d;
    logic          err_q, err_d;

    logic [W-1:0]  step_val;
    logic [DIGITS:0] chain;
    logic          load_digits_ok;
    logic          load_in_range;
    logic          load_ok;
    logic          wrap;
    op_e           op;

    // Ripple chain: the lowest decade always steps, higher ones step on rollover.
    assign chain[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_step u_step (
            .digit      (count_q[g*BCD_W +: BCD_W]),
            .up         (up),
            .carry_in   (chain[g]),
            .next_digit (step_val[g*BCD_W +: BCD_W]),
            .carry_out  (chain[g+1])
        );
    end

    // A load is accepted only if every nibble is a decimal digit and the value is below MODULUS.
    always_comb begin
        load_digits_ok = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (load_val[i*BCD_W +: BCD_W] > DIGIT_MAX_BCD) begin
                load_digits_ok = 1'b0;
            end
        end
        // With all-decimal digits, BCD ordering matches numeric ordering.
        load_in_range = {{BCD_W{1'b0}}, load_val} < MOD_BCD;
        load_ok       = load_digits_ok && load_in_range;
    end

    // Counting up wraps at MODULUS-1; counting down wraps at zero, which is
    // exactly when the borrow ripples out of the top decade.
    always_comb begin
        wrap = up ? (count_q == TOP_VAL) : chain[DIGITS];
    end

    // Resolve the edge's action: load beats enable beats hold.
    always_comb begin
        if (load) begin
            op = OpLoad;
        end else if (en) begin
            op = OpStep;
        end else begin
            op = OpHold;
        end
    end

    // Next-state for count and the single-cycle flags.
    always_comb begin
        count_d = count_q;
        carry_d = 1'b0;
        err_d   = 1'b0;
        unique case (op)
            OpLoad: begin
                if (load_ok) begin
                    count_d = load_val;
                end else begin
                    err_d = 1'b1;
                end
            end
            OpStep: begin
                if (wrap) begin
                    count_d = up ? '0 : TOP_VAL;
                    carry_d = 1'b1;
                end else begin
                    count_d = step_val;
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    // State registers; reset is the only asynchronous path into them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            carry_q <= carry_d;
            err_q   <= err_d;
        end
    end

    assign count    = count_q;
    assign carry    = carry_q;
    assign load_err = err_q;

endmodule
